// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate decoder with 2-entry skid buffer; IMM_GEN_ZICSR_EN enables CSR-immediate (fmt 6) decode.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instruction_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  immediate_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nx;
    logic [4:0] op;
    logic [2:0] f3;
    logic shift, accept, pop;
    logic [31:0] i_imm, d_imm;
    logic [2:0] d_fmt;
    logic d_ill;
    logic [XLEN-1:0] skid_imm;
    logic [2:0] skid_fmt;
    logic skid_ill;
    logic [TAG_W-1:0] skid_tag;
    assign op = instruction_i[6:2];
    assign f3 = instruction_i[14:12];
    assign shift = f3[1:0] == 2'b01;
    assign i_imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign ready_o = (state != TWO) && !rst_i;
    assign valid_o = state != EMPTY;
    assign accept = valid_i && ready_o;
    assign pop = valid_o && ready_i;
    always_comb begin
        d_imm = '0;
        d_fmt = 3'd0;
        d_ill = 1'b0;
        if (instruction_i[1:0] != 2'b11) d_ill = 1'b1;
        else case (op)
            5'b00000, 5'b11001: begin d_imm = i_imm; d_fmt = 3'd1; end
`ifdef IMM_GEN_ZICSR_EN
            5'b11100: begin
                d_imm = f3[2] ? {27'b0, instruction_i[19:15]} : i_imm;
                d_fmt = f3[2] ? 3'd6 : 3'd1;
            end
`else
            5'b11100: begin d_imm = i_imm; d_fmt = 3'd1; end
`endif
            // an RV32 shamt with bit 5 set has no legal encoding
            5'b00100: begin
                if (shift && XLEN == 32 && instruction_i[25]) d_ill = 1'b1;
                else begin
                    d_imm = shift ? {26'b0, instruction_i[25:20]} : i_imm;
                    d_fmt = 3'd1;
                end
            end
            5'b00110: begin
                if (XLEN == 32) d_ill = 1'b1;
                else begin
                    d_imm = shift ? {27'b0, instruction_i[24:20]} : i_imm;
                    d_fmt = 3'd1;
                end
            end
            5'b01000: begin d_imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]}; d_fmt = 3'd2; end
            5'b11000: begin d_imm = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25], instruction_i[11:8], 1'b0}; d_fmt = 3'd3; end
            5'b01101, 5'b00101: begin d_imm = {instruction_i[31:12], 12'b0}; d_fmt = 3'd4; end
            5'b11011: begin d_imm = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20], instruction_i[30:21], 1'b0}; d_fmt = 3'd5; end
            5'b01100, 5'b00011: d_ill = 1'b0;
            5'b01110: d_ill = XLEN == 32;
            default: d_ill = 1'b1;
        endcase
    end
    always_comb begin
        state_nx = state;
        if (flush_i) state_nx = EMPTY;
        else case (state)
            EMPTY: state_nx = accept ? ONE : EMPTY;
            ONE: state_nx = (accept && !pop) ? TWO : ((pop && !accept) ? EMPTY : ONE);
            TWO: state_nx = pop ? ONE : TWO;
            default: state_nx = EMPTY;
        endcase
    end
    always_ff @(posedge clk_i) state <= rst_i ? EMPTY : state_nx;
    // new words go straight to the output register unless it stays occupied
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            immediate_o <= '0;
            fmt_o <= '0;
            illegal_o <= 1'b0;
            tag_o <= '0;
            skid_imm <= '0;
            skid_fmt <= '0;
            skid_ill <= 1'b0;
            skid_tag <= '0;
        end else begin
            if (accept && (state == EMPTY || pop)) begin
                immediate_o <= XLEN'($signed(d_imm));
                fmt_o <= d_fmt;
                illegal_o <= d_ill;
                tag_o <= tag_i;
            end else if (state == TWO && pop) begin
                immediate_o <= skid_imm;
                fmt_o <= skid_fmt;
                illegal_o <= skid_ill;
                tag_o <= skid_tag;
            end
            if (accept && state == ONE && !pop) begin
                skid_imm <= XLEN'($signed(d_imm));
                skid_fmt <= d_fmt;
                skid_ill <= d_ill;
                skid_tag <= tag_i;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives XLEN=32 and XLEN=64 instances in lockstep against a queue-based reference model.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst_i, flush_i, valid_i, ready_i;
    logic [31:0] instruction_i, tag_i;
    logic r32, v32, il32, r64, v64, il64;
    logic [31:0] imm32, t32, t64;
    logic [63:0] imm64;
    logic [2:0] f32, f64;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [31:0] ins; logic [31:0] tag;} entry_t;
    entry_t q[$];
    always #5 clk = ~clk;
    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) d32 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r32),
        .instruction_i(instruction_i), .tag_i(tag_i), .valid_o(v32), .ready_i(ready_i),
        .immediate_o(imm32), .fmt_o(f32), .illegal_o(il32), .tag_o(t32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) d64 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r64),
        .instruction_i(instruction_i), .tag_i(tag_i), .valid_o(v64), .ready_i(ready_i),
        .immediate_o(imm64), .fmt_o(f64), .illegal_o(il64), .tag_o(t64));
    function automatic longint sx(input longint x, input int b);
        return (x <<< (64 - b)) >>> (64 - b);
    endfunction
    // reference decoder: immediate value as a signed 64-bit integer, truncated to the datapath width
    function automatic void model(input logic [31:0] i, input int xl, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
        longint v = 0;
        logic sh = i[14:12] == 3'b001 || i[14:12] == 3'b101;
        fmt = 3'd0;
        ill = 1'b0;
        if (i[1:0] != 2'b11) ill = 1'b1;
        else case (i[6:2])
            5'b00000, 5'b11001, 5'b11100: begin
                v = sx(longint'(i[31:20]), 12); fmt = 3'd1;
`ifdef IMM_GEN_ZICSR_EN
                if (i[6:2] == 5'b11100 && i[14]) begin v = longint'(i[19:15]); fmt = 3'd6; end
`endif
            end
            5'b00100: begin
                if (!sh) begin v = sx(longint'(i[31:20]), 12); fmt = 3'd1; end
                else if (xl == 32 && i[25]) ill = 1'b1;
                else begin v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]); fmt = 3'd1; end
            end
            5'b00110: begin
                if (xl == 32) ill = 1'b1;
                else begin v = sh ? longint'(i[24:20]) : sx(longint'(i[31:20]), 12); fmt = 3'd1; end
            end
            5'b01000: begin v = sx(longint'({i[31:25], i[11:7]}), 12); fmt = 3'd2; end
            5'b11000: begin v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); fmt = 3'd3; end
            5'b01101, 5'b00101: begin v = sx(longint'({i[31:12], 12'b0}), 32); fmt = 3'd4; end
            5'b11011: begin v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); fmt = 3'd5; end
            5'b01100, 5'b00011: fmt = 3'd0;
            5'b01110: ill = xl == 32;
            default: ill = 1'b1;
        endcase
        imm = (xl == 32) ? {32'b0, v[31:0]} : 64'(v);
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask
    task automatic compare();
        logic mv, mr, ill;
        logic [63:0] imm;
        logic [2:0] fmt;
        mv = q.size() > 0;
        mr = !rst_i && q.size() < 2;
        chk("valid32", 64'(v32), 64'(mv));
        chk("valid64", 64'(v64), 64'(mv));
        chk("ready32", 64'(r32), 64'(mr));
        chk("ready64", 64'(r64), 64'(mr));
        if (mv) begin
            model(q[0].ins, 32, imm, fmt, ill);
            chk("imm32", 64'(imm32), imm);
            chk("fmt32", 64'(f32), 64'(fmt));
            chk("ill32", 64'(il32), 64'(ill));
            chk("tag32", 64'(t32), 64'(q[0].tag));
            model(q[0].ins, 64, imm, fmt, ill);
            chk("imm64", imm64, imm);
            chk("fmt64", 64'(f64), 64'(fmt));
            chk("ill64", 64'(il64), 64'(ill));
            chk("tag64", 64'(t64), 64'(q[0].tag));
        end
    endtask
    task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic rdy, input logic fl, input logic rs);
        logic acc, pp;
        valid_i = v; instruction_i = ins; tag_i = tg; ready_i = rdy; flush_i = fl; rst_i = rs;
        #1 compare();
        acc = v && !rs && q.size() < 2;
        pp = rdy && q.size() > 0;
        @(posedge clk);
        if (rs || fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back('{ins, tg});
        end
        @(negedge clk);
        #1;
    endtask
    task automatic pin(input logic [31:0] ins, input int xl, input logic [63:0] e_imm,
                       input logic [2:0] e_fmt, input logic e_ill);
        logic [63:0] imm;
        logic [2:0] fmt;
        logic ill;
        model(ins, xl, imm, fmt, ill);
        chk($sformatf("model_imm_%h_%0d", ins, xl), imm, e_imm);
        chk($sformatf("model_fmt_%h_%0d", ins, xl), 64'(fmt), 64'(e_fmt));
        chk($sformatf("model_ill_%h_%0d", ins, xl), 64'(ill), 64'(e_ill));
    endtask
    localparam logic [4:0] OPS [13] = '{5'b00000, 5'b00100, 5'b11001, 5'b11100, 5'b00110, 5'b01000,
        5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b01100, 5'b01110, 5'b00011};
    localparam logic [31:0] NOP = 32'h0000_0013;
    initial begin
        logic [31:0] ins;
        pin(32'hFFF00093, 32, 64'hFFFFFFFF, 3'd1, 1'b0);
        pin(32'hFE112E23, 32, 64'hFFFFFFFC, 3'd2, 1'b0);
        pin(32'hFE000EE3, 32, 64'hFFFFFFFC, 3'd3, 1'b0);
        pin(32'h800000B7, 64, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        pin(32'h03F09093, 64, 64'h3F, 3'd1, 1'b0);
        pin(32'h03F09093, 32, 64'h0, 3'd0, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
        pin(32'h300FD073, 32, 64'h1F, 3'd6, 1'b0);
`else
        pin(32'h300FD073, 32, 64'h300, 3'd1, 1'b0);
`endif
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; instruction_i = NOP; tag_i = '0;
        @(posedge clk);
        @(negedge clk);
        tick(1'b0, NOP, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_fmt", 64'(f64), 64'h0);
        chk("rst_ill", 64'(il64), 64'h0);
        chk("rst_tag", 64'(t64), 64'h0);
        tick(1'b1, 32'hFFF00093, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("addi_valid", 64'(v32), 64'h1);
        chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
        chk("addi_tag", 64'(t32), 64'h55);
        tick(1'b1, 32'hFE112E23, 1, 1'b1, 1'b0, 1'b0);
        chk("sw_imm", 64'(imm32), 64'hFFFFFFFC);
        chk("sw_fmt", 64'(f32), 64'h2);
        tick(1'b1, 32'hFE000EE3, 2, 1'b1, 1'b0, 1'b0);
        chk("beq_imm", 64'(imm32), 64'hFFFFFFFC);
        chk("beq_fmt", 64'(f32), 64'h3);
        tick(1'b1, 32'h800000B7, 3, 1'b1, 1'b0, 1'b0);
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        tick(1'b1, 32'h03F09093, 4, 1'b1, 1'b0, 1'b0);
        chk("slli64_imm", imm64, 64'h3F);
        chk("slli32_ill", 64'(il32), 64'h1);
        chk("slli32_imm", 64'(imm32), 64'h0);
        tick(1'b1, 32'h300FD073, 9, 1'b1, 1'b0, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        chk("csrrwi_imm", 64'(imm32), 64'h1F);
        chk("csrrwi_fmt", 64'(f32), 64'h6);
`else
        chk("csrrwi_imm", 64'(imm32), 64'h300);
        chk("csrrwi_fmt", 64'(f32), 64'h1);
`endif
        tick(1'b0, NOP, 0, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 3; t++) tick(1'b1, NOP, t, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 64'(r32), 64'h0);
        tick(1'b1, NOP, 3, 1'b1, 1'b0, 1'b0);
        tick(1'b1, NOP, 3, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) tick(1'b0, NOP, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, NOP, 1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, NOP, 2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, NOP, 3, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(v32), 64'h0);
        chk("flush_ready", 64'(r32), 64'h1);
        for (int t = 0; t < 2; t++) tick(1'b0, NOP, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 32'hFFF00093, 1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'hFFF00093, 2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'hFFF00093, 3, 1'b0, 1'b0, 1'b1);
        chk("rst2_valid", 64'(v64), 64'h0);
        chk("rst2_imm", imm64, 64'h0);
        chk("rst2_fmt", 64'(f64), 64'h0);
        chk("rst2_tag", 64'(t64), 64'h0);
        tick(1'b0, NOP, 0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 7) ins[6:2] = OPS[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) != 0) ins[1:0] = 2'b11;
            tick($urandom_range(0, 9) < 7, ins, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
